// File: rtl/pixel_stream_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_stream_mux
//  Description : Packet-locked N:1 pixel stream multiplexer. Arbitrates in
//                IDLE (static select or round-robin), then forwards one whole
//                line (packet) from the granted channel through a single
//                registered output stage with valid/ready flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_mux #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_valid,
   input  logic [NUM_CH-1:0]        in_last,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic                     mode,
   input  logic [SEL_W-1:0]         sel,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   output logic                     out_last,
   output logic [SEL_W-1:0]         out_ch,
   input  logic                     out_ready
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(NUM_CH - 1);

   // last_g doubles as the current grant: it is written on every grant and
   // only read as "the granted channel" while LOCKED.
   state_t              state_q, state_d;
   logic [SEL_W-1:0]    last_g_q, last_g_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic [SEL_W-1:0]    out_ch_q, out_ch_d;

   logic                w_g_valid;
   logic                w_g_last;
   logic [DATA_W-1:0]   w_g_data;
   logic                w_arb_hit;
   logic [SEL_W-1:0]    w_arb_ch;
   logic                w_take;

   // Pick out the granted channel's beat and handshake flags
   always_comb begin
      w_g_valid = 1'b0;
      w_g_last  = 1'b0;
      w_g_data  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (last_g_q == SEL_W'(k)) begin
            w_g_valid = in_valid[k];
            w_g_last  = in_last[k];
            w_g_data  = in_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // Arbitration: static select (out-of-range sel never matches) or a
   // round-robin search starting just after the previous grant
   always_comb begin
      w_arb_hit = 1'b0;
      w_arb_ch  = '0;
      if (mode) begin
         for (int i = 1; i <= NUM_CH; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (!w_arb_hit && in_valid[k] &&
                   ((int'(last_g_q) + i == k) || (int'(last_g_q) + i == k + NUM_CH))) begin
                  w_arb_hit = 1'b1;
                  w_arb_ch  = SEL_W'(k);
               end
            end
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k) && in_valid[k]) begin
               w_arb_hit = 1'b1;
               w_arb_ch  = SEL_W'(k);
            end
         end
      end
   end

   // Ready only toward the locked channel, and only when the output slot frees
   always_comb begin
      in_ready = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!rst && state_q == ST_LOCKED && last_g_q == SEL_W'(k)) begin
            in_ready[k] = !out_valid_q || out_ready;
         end
      end
   end

   assign w_take = (state_q == ST_LOCKED) && w_g_valid && (!out_valid_q || out_ready);

   // Next state: grant in IDLE, load/drain the output stage, unlock on last
   always_comb begin
      state_d     = state_q;
      last_g_d    = last_g_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (w_take) begin
         out_valid_d = 1'b1;
         out_data_d  = w_g_data;
         out_last_d  = w_g_last;
         out_ch_d    = last_g_q;
         if (w_g_last) begin
            state_d = ST_IDLE;
         end
      end
      if (state_q == ST_IDLE && w_arb_hit) begin
         state_d  = ST_LOCKED;
         last_g_d = w_arb_ch;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         last_g_q    <= c_last_ch;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_ch_q    <= '0;
      end else begin
         state_q     <= state_d;
         last_g_q    <= last_g_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_ch_q    <= out_ch_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_ch    = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_stream_mux
//  Description : Self-checking bench for pixel_stream_mux. Directed scenarios
//                plus randomized packet traffic against a packet-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_mux;
   localparam int DW  = 8;
   localparam int NCH = 4;
   localparam int SW  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [NCH*DW-1:0]   in_data;
   logic [NCH-1:0]      in_valid, in_last, in_ready;
   logic                mode;
   logic [SW-1:0]       sel;
   logic [DW-1:0]       out_data;
   logic                out_valid, out_last, out_ready;
   logic [SW-1:0]       out_ch;

   logic [3*DW-1:0]     in_data3;
   logic [2:0]          in_valid3, in_last3, in_ready3;
   logic                mode3;
   logic [1:0]          sel3;
   logic [DW-1:0]       out_data3;
   logic                out_valid3, out_last3, out_ready3;
   logic [1:0]          out_ch3;

   pixel_stream_mux #(.DATA_W(DW), .NUM_CH(NCH), .SEL_W(SW)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_valid(out_valid), .out_last(out_last), .out_ch(out_ch), .out_ready(out_ready)
   );

   pixel_stream_mux #(.DATA_W(DW), .NUM_CH(3), .SEL_W(2)) dut3 (
      .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3),
      .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
      .out_valid(out_valid3), .out_last(out_last3), .out_ch(out_ch3), .out_ready(out_ready3)
   );

   typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
   typedef struct { int ch; logic [DW-1:0] data; logic last; int cyc; } obs_t;

   beat_t        src_q [NCH][$];
   obs_t         got_q [$];
   obs_t         exp_q [$];
   int           checks = 0;
   int           errors = 0;
   int           bubble_pct;
   bit           rand_ready;
   int           rdy_pat [$];
   int           sel_switch_cyc;
   logic [SW-1:0] sel_after;

   task automatic clear_cfg();
      bubble_pct     = 0;
      rand_ready     = 1'b0;
      sel_switch_cyc = -1;
      sel_after      = '0;
      rdy_pat.delete();
      got_q.delete();
      exp_q.delete();
      for (int k = 0; k < NCH; k++) src_q[k].delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = '0; in_valid3 = '0; out_ready = 1'b1; out_ready3 = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic add_beat(input int ch, input logic [DW-1:0] d, input logic l);
      beat_t b;
      b.data = d; b.last = l;
      src_q[ch].push_back(b);
   endtask

   task automatic add_packet(input int ch, input int len);
      for (int i = 0; i < len; i++) add_beat(ch, DW'($urandom), (i == len - 1));
   endtask

   task automatic push_exp(input int ch, input beat_t b);
      obs_t o;
      o.ch = ch; o.data = b.data; o.last = b.last; o.cyc = 0;
      exp_q.push_back(o);
   endtask

   // Source/sink driver: presents queue heads, applies out_ready, records
   // every beat leaving the output, and watches the stall/ready rules.
   task automatic run_traffic(input int n_expect, input int max_cyc);
      int            cyc;
      bit            done;
      logic [NCH-1:0] acc;
      logic          hold, drain, s_last;
      logic [DW-1:0] s_data;
      logic [SW-1:0] s_ch;
      obs_t          o;
      cyc = 0; done = 1'b0;
      got_q.delete();
      while (!done) begin
         @(negedge clk);
         if (cyc == sel_switch_cyc) sel = sel_after;
         for (int k = 0; k < NCH; k++) begin
            if (src_q[k].size() > 0 && int'($urandom_range(99)) >= bubble_pct) begin
               in_valid[k] = 1'b1;
               in_data[k*DW +: DW] = src_q[k][0].data;
               in_last[k] = src_q[k][0].last;
            end else begin
               in_valid[k] = 1'b0;
               in_data[k*DW +: DW] = DW'($urandom);
               in_last[k] = 1'($urandom_range(1));
            end
         end
         if (rdy_pat.size() > 0) out_ready = 1'(rdy_pat.pop_front());
         else if (rand_ready)    out_ready = 1'($urandom_range(1));
         else                    out_ready = 1'b1;
         #1;
         acc   = in_valid & in_ready;
         hold  = out_valid && !out_ready;
         drain = out_valid && out_ready;
         s_data = out_data; s_last = out_last; s_ch = out_ch;
         checks++;
         if ($countones(in_ready) > 1) begin
            errors++; $display("FAIL ready_onehot cyc %0d in_ready=%b, at most one bit allowed", cyc, in_ready);
         end
         if (hold) begin
            checks++;
            if (in_ready !== '0) begin
               errors++; $display("FAIL stall_ready cyc %0d in_ready=%b, required 0", cyc, in_ready);
            end
         end
         @(posedge clk); #1;
         for (int k = 0; k < NCH; k++) if (acc[k]) src_q[k].delete(0);
         if (drain) begin
            o.ch = int'(s_ch); o.data = s_data; o.last = s_last; o.cyc = cyc;
            got_q.push_back(o);
         end
         if (hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== s_data || out_last !== s_last || out_ch !== s_ch) begin
               errors++;
               $display("FAIL hold_stable cyc %0d got v%b d%h l%b c%0d, required v1 d%h l%b c%0d",
                        cyc, out_valid, out_data, out_last, out_ch, s_data, s_last, s_ch);
            end
         end
         cyc++;
         if (got_q.size() >= n_expect && out_valid === 1'b0) begin
            done = 1'b1;
         end else if (cyc >= max_cyc) begin
            checks++; errors++;
            $display("FAIL traffic_timeout got %0d beats, required %0d", got_q.size(), n_expect);
            done = 1'b1;
         end
      end
      in_valid = '0;
   endtask

   task automatic test_reset();
      mode = 1'b0; sel = '0; in_valid = '1; in_last = '0; in_data = '1; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1; #1;
      checks++;
      if (in_ready !== '0) begin errors++; $display("FAIL reset_ready_during got %b required 0000", in_ready); end
      @(posedge clk); #1;
      checks += 4;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
      if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data got %h required 00", out_data); end
      if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_out_last got %b required 0", out_last); end
      if (out_ch !== '0)      begin errors++; $display("FAIL reset_out_ch got %0d required 0", out_ch); end
      @(negedge clk);
      rst = 1'b0; #1;
      checks++;
      if (in_ready !== '0) begin errors++; $display("FAIL reset_ready_after got %b required 0000", in_ready); end
      @(negedge clk); #1;
      checks++;
      if (in_ready !== 4'b0001) begin errors++; $display("FAIL first_grant_ready got %b required 0001", in_ready); end
      do_reset();
   endtask

   task automatic test_static_basic();
      logic [DW-1:0] vals [3];
      clear_cfg();
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      mode = 1'b0; sel = 2'd2;
      for (int i = 0; i < 3; i++) add_beat(2, vals[i], (i == 2));
      run_traffic(3, 50);
      checks++;
      if (got_q.size() != 3) begin errors++; $display("FAIL static_count got %0d required 3", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
         checks++;
         if (got_q[i].ch != 2 || got_q[i].data !== vals[i] || got_q[i].last !== (i == 2) || got_q[i].cyc != 2 + i) begin
            errors++;
            $display("FAIL static_beat%0d got ch%0d d%h l%b cyc%0d, required ch2 d%h l%b cyc%0d",
                     i, got_q[i].ch, got_q[i].data, got_q[i].last, got_q[i].cyc, vals[i], (i == 2), 2 + i);
         end
      end
   endtask

   task automatic test_rr_fairness();
      do_reset();
      clear_cfg();
      mode = 1'b1;
      for (int r = 0; r < 3; r++) for (int k = 0; k < NCH; k++) add_beat(k, DW'(16 * k + r), 1'b1);
      run_traffic(12, 200);
      checks++;
      if (got_q.size() != 12) begin errors++; $display("FAIL rr_count got %0d required 12", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 12; i++) begin
         checks++;
         if (got_q[i].ch != i % 4 || got_q[i].data !== DW'(16 * (i % 4) + i / 4)) begin
            errors++;
            $display("FAIL rr_order beat%0d got ch%0d d%h, required ch%0d d%h",
                     i, got_q[i].ch, got_q[i].data, i % 4, DW'(16 * (i % 4) + i / 4));
         end
         if (i > 0) begin
            checks++;
            if (got_q[i].cyc - got_q[i-1].cyc != 2) begin
               errors++; $display("FAIL rr_spacing beat%0d got %0d cycles required 2", i, got_q[i].cyc - got_q[i-1].cyc);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      clear_cfg();
      mode = 1'b0; sel = 2'd1;
      add_packet(1, 6);
      add_packet(0, 2);
      for (int i = 0; i < 6; i++) push_exp(1, src_q[1][i]);
      rdy_pat = '{1, 1, 1, 0, 0, 0};
      run_traffic(6, 100);
      checks++;
      if (got_q.size() != 6) begin errors++; $display("FAIL bp_count got %0d required 6", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 6; i++) begin
         checks++;
         if (got_q[i].ch != 1 || got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
            errors++;
            $display("FAIL bp_beat%0d got ch%0d d%h l%b, required ch1 d%h l%b",
                     i, got_q[i].ch, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last);
         end
      end
      checks++;
      if (src_q[0].size() != 2) begin errors++; $display("FAIL bp_ignored_ch0 got %0d beats left required 2", src_q[0].size()); end
   endtask

   task automatic test_lock();
      clear_cfg();
      mode = 1'b0; sel = 2'd1;
      add_packet(1, 4);
      add_packet(3, 2);
      for (int i = 0; i < 4; i++) push_exp(1, src_q[1][i]);
      for (int i = 0; i < 2; i++) push_exp(3, src_q[3][i]);
      sel_switch_cyc = 3; sel_after = 2'd3;
      run_traffic(6, 100);
      checks++;
      if (got_q.size() != 6) begin errors++; $display("FAIL lock_count got %0d required 6", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 6; i++) begin
         checks++;
         if (got_q[i].ch != exp_q[i].ch || got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
            errors++;
            $display("FAIL lock_beat%0d got ch%0d d%h l%b, required ch%0d d%h l%b", i, got_q[i].ch,
                     got_q[i].data, got_q[i].last, exp_q[i].ch, exp_q[i].data, exp_q[i].last);
         end
      end
   endtask

   task automatic test_invalid_sel();
      int lg, n, cyc, want;
      do_reset();
      mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_last3 = 3'b111; out_ready3 = 1'b1;
      in_data3 = {8'h33, 8'h22, 8'h11};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         checks++;
         if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
            errors++; $display("FAIL badsel_idle cyc %0d got ready %b valid %b, required 000 0", i, in_ready3, out_valid3);
         end
      end
      mode3 = 1'b1; lg = 2; n = 0; cyc = 0;
      while (n < 4 && cyc < 40) begin
         @(negedge clk); #1;
         if (out_valid3 === 1'b1) begin
            want = (lg + 1) % 3;
            checks++;
            if (out_ch3 !== 2'(want) || out_data3 !== DW'(17 * (want + 1))) begin
               errors++; $display("FAIL rr3_wrap beat%0d got ch%0d d%h, required ch%0d d%h",
                                  n, out_ch3, out_data3, want, DW'(17 * (want + 1)));
            end
            lg = want; n++;
         end
         cyc++;
      end
      checks++;
      if (n != 4) begin errors++; $display("FAIL rr3_timeout got %0d beats required 4", n); end
      in_valid3 = '0;
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      mode = 1'b1; in_valid = 4'b1010; in_last = '0; out_ready = 1'b1;
      in_data = {8'h44, 8'h33, 8'h22, 8'h11};
      @(negedge clk); @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1) begin
         errors++; $display("FAIL rmid_pre got valid %b ch%0d, required 1 ch1", out_valid, out_ch);
      end
      rst = 1'b1; #1;
      checks++;
      if (in_ready !== '0) begin errors++; $display("FAIL rmid_ready_during got %b required 0000", in_ready); end
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0 || out_last !== 1'b0) begin
         errors++; $display("FAIL rmid_cleared got v%b d%h c%0d l%b, required v0 d00 c0 l0", out_valid, out_data, out_ch, out_last);
      end
      rst = 1'b0; #1;
      checks++;
      if (in_ready !== '0) begin errors++; $display("FAIL rmid_ready_after got %b required 0000", in_ready); end
      @(negedge clk); #1;
      checks++;
      if (in_ready !== 4'b0010) begin errors++; $display("FAIL rmid_regrant got %b required 0010", in_ready); end
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h22) begin
         errors++; $display("FAIL rmid_beat got v%b c%0d d%h, required v1 c1 d22", out_valid, out_ch, out_data);
      end
      do_reset();
   endtask

   task automatic test_random_rr();
      beat_t tmp [NCH][$];
      beat_t b;
      int    lg, c;
      do_reset();
      clear_cfg();
      mode = 1'b1; rand_ready = 1'b1;
      for (int k = 0; k < NCH; k++) begin
         int np;
         np = int'($urandom_range(1, 3));
         for (int p = 0; p < np; p++) add_packet(k, int'($urandom_range(1, 5)));
      end
      // Packet-level model: whole packets in round-robin order after the last grant
      for (int k = 0; k < NCH; k++) tmp[k] = src_q[k];
      lg = NCH - 1;
      forever begin
         c = -1;
         for (int i = 1; i <= NCH; i++) if (c < 0 && tmp[(lg + i) % NCH].size() > 0) c = (lg + i) % NCH;
         if (c < 0) break;
         do begin
            b = tmp[c].pop_front();
            push_exp(c, b);
         end while (!b.last);
         lg = c;
      end
      run_traffic(exp_q.size(), 2000);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rr_rand_count got %0d required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i].ch != exp_q[i].ch || got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
            errors++;
            $display("FAIL rr_rand_beat%0d got ch%0d d%h l%b, required ch%0d d%h l%b", i, got_q[i].ch,
                     got_q[i].data, got_q[i].last, exp_q[i].ch, exp_q[i].data, exp_q[i].last);
         end
      end
   endtask

   task automatic test_random_static();
      int s;
      int left [NCH];
      clear_cfg();
      s = int'($urandom_range(0, NCH - 1));
      mode = 1'b0; sel = SW'(s); rand_ready = 1'b1; bubble_pct = 30;
      for (int k = 0; k < NCH; k++) begin
         int np;
         np = int'($urandom_range(1, 3));
         for (int p = 0; p < np; p++) add_packet(k, int'($urandom_range(1, 5)));
         left[k] = src_q[k].size();
      end
      for (int i = 0; i < src_q[s].size(); i++) push_exp(s, src_q[s][i]);
      run_traffic(exp_q.size(), 2000);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL st_rand_count got %0d required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i].ch != s || got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last) begin
            errors++;
            $display("FAIL st_rand_beat%0d got ch%0d d%h l%b, required ch%0d d%h l%b", i, got_q[i].ch,
                     got_q[i].data, got_q[i].last, s, exp_q[i].data, exp_q[i].last);
         end
      end
      for (int k = 0; k < NCH; k++) begin
         if (k != s) begin
            checks++;
            if (src_q[k].size() != left[k]) begin
               errors++; $display("FAIL st_rand_ignored ch%0d got %0d beats left required %0d", k, src_q[k].size(), left[k]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;
      in_valid3 = '0; in_last3 = '0; in_data3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b1;
      clear_cfg();
      test_reset();
      test_static_basic();
      test_rr_fairness();
      test_backpressure();
      test_lock();
      test_invalid_sel();
      test_reset_mid_packet();
      for (int n = 0; n < 3; n++) test_random_rr();
      for (int n = 0; n < 3; n++) test_random_static();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
